md_pipe_ctrl: RTL
=================

Name: md_pipe_ctrl

Overview:
- Sequences the multi-cycle multiply/divide unit and produces the stall and flush controls for the F/D/E pipeline registers.
- Tracks mult/div occupancy with a down-counter.
- Merges that occupancy with the data-hazard stall request from the decode-stage hazard logic.
- Outputs drive the D-register enable, the F (PC) enable and the E-register clear.
- Pending exceptions or interrupts override any stall so the flush proceeds.

Parameters:
- MULT_CYCLES, 5, number of busy cycles after a mult/multu start (must be >=1)
- DIV_CYCLES, 10, number of busy cycles after a div/divu start (must be >=1)
- CW, 4, counter width; must satisfy 2^CW > max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_mult  in  1  E-stage instruction is mult/multu (level, one cycle per instruction)
- start_div  in  1  E-stage instruction is div/divu
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- stall_data  in  1  data-hazard stall request from decode hazard logic
- exc_int  in  1  exception/interrupt taken this cycle (pipeline flush)
- busy  out  1  mult/div unit occupied
- cnt_o  out  CW  remaining busy cycles (0 when idle)
- hilo_we  out  1  one-cycle pulse: HI/LO result ready to commit
- done_div  out  1  qualifies hilo_we: 1 = div result, 0 = mult result
- en_F  out  1  PC / F-stage enable
- en_D  out  1  enable for the D pipeline register
- clr_E  out  1  clear (bubble insert) for the E pipeline register

Behaviour:
- State: IDLE, MULT, DIV; registered cnt[CW-1:0] and registered flag is_div.
- Reset (asynchronous) forces: state=IDLE, cnt=0, is_div=0, busy=0, hilo_we=0, done_div=0.
- Reset mid-operation aborts silently; no hilo_we pulse is produced.
- Start acceptance: start_eff = (start_mult|start_div) & ~exc_int & (state==IDLE).
  - A start during an exc_int cycle is dropped, because that instruction is being flushed.
- IDLE + start_mult -> MULT, cnt=MULT_CYCLES-1.
- IDLE + start_div -> DIV, cnt=DIV_CYCLES-1, is_div=1.
- start_mult and start_div asserted together: div takes priority.
- MULT/DIV: cnt decrements each cycle.
  - In the cycle cnt==0, hilo_we=1 and done_div=is_div (combinational from state), then next state is IDLE.
- Start in a non-IDLE state is ignored; the pipeline stalls, so it cannot legally occur.
- Timing: start seen in cycle t, then busy=1 for cycles t+1..t+N and hilo_we=1 in cycle t+N (N = MULT_CYCLES or DIV_CYCLES).
- busy = (state!=IDLE); cnt_o = cnt.
- exc_int while MULT/DIV: the operation continues to completion. The instruction already left E, so its result must commit.
- md_stall = md_use_D & (busy | start_mult | start_div).
- stall = (stall_data | md_stall) & ~exc_int.
- en_F = ~stall, en_D = ~stall, clr_E = stall; all are combinational.
- exc_int=1 forces en_F=1, en_D=1, clr_E=0. The registers flush through their own exc_int input.
- Last busy cycle (cnt==0) still stalls; the D-stage md instruction advances the following cycle.

Optional Feature:
- Macro MD_STALL_CNT_EN.
- When defined, adds output stall_cnt [31:0]: a free-running count of cycles where stall=1, split into md_stall_cnt [31:0] (md_stall&~exc_int) and total.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, neither port nor counters exist; all other behaviour is identical.

Test Plan:
- Reset, then start_mult pulse at t=0 -> busy=1 t=1..5, cnt_o 4,3,2,1,0, hilo_we=1 and done_div=0 only at t=5, busy=0 at t=6.
- start_div at t=0, md_use_D=1 held -> en_D=en_F=0 and clr_E=1 for t=0..10, en_D=1 at t=11, hilo_we & done_div at t=10.
- start_mult and exc_int same cycle -> state stays IDLE, busy=0, no hilo_we; en_D=1, clr_E=0.
- start_div at t=0, exc_int at t=3 with md_use_D=1 -> en_D=1 at t=3, busy still 1, hilo_we at t=10.
- stall_data=1 with busy=0 -> en_D=0, clr_E=1; stall_data=1 with exc_int=1 -> en_D=1, clr_E=0.
- start_div at t=0, reset asserted asynchronously mid-cycle t=4 -> busy=0 and cnt_o=0 immediately; no hilo_we at t=10.

Source files
------------

// File: rtl/md_pipe_ctrl.sv
// Multiply/divide sequencer with F/D/E pipeline stall and flush control.
// Optional stall counters are enabled with `define MD_STALL_CNT_EN.
module md_pipe_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CW          = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_mult,
  input  logic          start_div,
  input  logic          md_use_D,
  input  logic          stall_data,
  input  logic          exc_int,
  output logic          busy,
  output logic [CW-1:0] cnt_o,
  output logic          hilo_we,
  output logic          done_div,
  output logic          en_F,
  output logic          en_D,
`ifdef MD_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   md_stall_cnt,
`endif
  output logic          clr_E
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          is_div, is_div_nx;
  logic          start_eff;
  logic          md_stall;
  logic          stall;

  // A start coinciding with a flush belongs to the flushed instruction.
  assign start_eff = (start_mult | start_div) & ~exc_int & (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      is_div <= is_div_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    is_div_nx = is_div;
    hilo_we   = 1'b0;
    case (state)
      IDLE: begin
        if (start_eff) begin
          if (start_div) begin
            state_nx  = DIV;
            cnt_nx    = DIV_LOAD;
            is_div_nx = 1'b1;
          end else begin
            state_nx  = MULT;
            cnt_nx    = MULT_LOAD;
            is_div_nx = 1'b0;
          end
        end
      end
      MULT, DIV: begin
        if (cnt == '0) begin
          hilo_we  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign done_div = hilo_we & is_div;
  assign busy     = (state != IDLE);
  assign cnt_o    = cnt;

  // exc_int wins over every stall source so the flush can proceed.
  assign md_stall = md_use_D & (busy | start_mult | start_div);
  assign stall    = (stall_data | md_stall) & ~exc_int;
  assign en_F     = ~stall;
  assign en_D     = ~stall;
  assign clr_E    = stall;

`ifdef MD_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall)
        stall_cnt <= stall_cnt + 32'd1;
      if (md_stall & ~exc_int)
        md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
